// File: rtl/training_sequencer_pkg.sv
// Shared types for the training sequencer: FSM states, input vector width
// and the stored training sample record.
package training_sequencer_pkg;

   localparam int NUM_INPUTS = 32;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PRESENT  = 3'd1,
      CAPTURE  = 3'd2,
      UPDATE   = 3'd3,
      ADVANCE  = 3'd4
   } ts_state_t;

   typedef struct {
      real dendrites [NUM_INPUTS];
      real target;
   } sample_t;

endpackage

// File: rtl/training_sequencer_sample_store.sv
// Training sample storage: a register array with one write port and a
// combinational read port. Write indices outside 0..NUM_SAMPLES-1 match
// no slot and are dropped.
module sample_store
   import training_sequencer_pkg::*;
#(
   parameter int NUM_SAMPLES = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_wr_en,
   input  logic [3:0] i_wr_idx,
   input  real        i_wr_dendrites [NUM_INPUTS],
   input  real        i_wr_target,
   input  logic [3:0] i_rd_idx,
   output real        o_rd_dendrites [NUM_INPUTS],
   output real        o_rd_target
);

   sample_t r_mem [NUM_SAMPLES];

   // Clear every slot on reset; otherwise write the addressed slot.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int s = 0; s < NUM_SAMPLES; s++) begin
            for (int d = 0; d < NUM_INPUTS; d++) begin
               r_mem[s].dendrites[d] <= 0.0;
            end
            r_mem[s].target <= 0.0;
         end
      end else if (i_wr_en) begin
         for (int s = 0; s < NUM_SAMPLES; s++) begin
            if (i_wr_idx == 4'(s)) begin
               r_mem[s].dendrites <= i_wr_dendrites;
               r_mem[s].target    <= i_wr_target;
            end
         end
      end
   end

   // Combinational read of the slot selected by the sequencer.
   always_comb begin
      for (int d = 0; d < NUM_INPUTS; d++) begin
         o_rd_dendrites[d] = 0.0;
      end
      o_rd_target = 0.0;
      for (int s = 0; s < NUM_SAMPLES; s++) begin
         if (i_rd_idx == 4'(s)) begin
            o_rd_dendrites = r_mem[s].dendrites;
            o_rd_target    = r_mem[s].target;
         end
      end
   end

endmodule

// File: rtl/training_sequencer.sv
// Training sequencer: presents stored samples to a neuron, waits for the
// axon to settle, captures target-axon as the backprop error, holds it for
// one full clock (UPDATE) so a negedge weight commit sees a stable value,
// then advances. Runs a latched number of epochs and reports per-epoch
// sum of squared errors. Cycles per sample = SETTLE_CYCLES + 3.
// Handshake: ts_start is a one-cycle request accepted only in IDLE; ts_done
// is a one-cycle pulse; ts_busy is high in every non-IDLE state.
module training_sequencer
   import training_sequencer_pkg::*;
#(
   parameter int NUM_SAMPLES   = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        ts_clock,
   input  logic        ts_reset,
   input  logic        ts_load_valid,
   input  logic [3:0]  ts_load_index,
   input  real         ts_load_dendrites [NUM_INPUTS],
   input  real         ts_load_target,
   input  logic        ts_start,
   input  logic [15:0] ts_epochs,
   input  real         ts_ratio_in,
   input  real         ts_axon,
   output real         ts_dendrites [NUM_INPUTS],
   output real         ts_backprop,
   output real         ts_training_ratio,
   output logic        ts_busy,
   output logic        ts_done,
   output logic [15:0] ts_epoch,
   output logic [3:0]  ts_sample_idx,
   output real         ts_epoch_error,
   output ts_state_t   ts_dbg_state
);

   ts_state_t   r_state;
   ts_state_t   w_state_nxt;
   logic [3:0]  r_settle;
   logic [3:0]  r_idx;
   logic [15:0] r_epochs_tgt;
   logic [15:0] r_epoch;
   logic [15:0] w_epoch_inc;
   logic        r_done;
   logic        w_last;
   logic        w_finish;
   logic        w_load_en;
   real         r_backprop;
   real         r_ratio;
   real         r_run_err;
   real         r_epoch_err;
   real         w_err;
   real         w_rd_target;
   real         w_rd_dendrites [NUM_INPUTS];

   // Loads are only accepted while idle.
   assign w_load_en = ts_load_valid && (r_state == IDLE);

   sample_store #(
      .NUM_SAMPLES (NUM_SAMPLES)
   ) u_store (
      .i_clk          (ts_clock),
      .i_rst          (ts_reset),
      .i_wr_en        (w_load_en),
      .i_wr_idx       (ts_load_index),
      .i_wr_dendrites (ts_load_dendrites),
      .i_wr_target    (ts_load_target),
      .i_rd_idx       (r_idx),
      .o_rd_dendrites (w_rd_dendrites),
      .o_rd_target    (w_rd_target)
   );

   assign w_err       = w_rd_target - ts_axon;
   assign w_last      = (r_idx == 4'(NUM_SAMPLES - 1));
   assign w_epoch_inc = (r_epoch == 16'hFFFF) ? r_epoch : r_epoch + 16'd1;
   assign w_finish    = (w_epoch_inc == r_epochs_tgt);

   // State register.
   always_ff @(posedge ts_clock) begin
      if (ts_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (ts_start && (ts_epochs != 16'd0)) w_state_nxt = PRESENT;
         PRESENT:  if (r_settle == 4'(SETTLE_CYCLES - 1)) w_state_nxt = CAPTURE;
         CAPTURE:  w_state_nxt = UPDATE;
         UPDATE:   w_state_nxt = ADVANCE;
         ADVANCE:  w_state_nxt = (w_last && w_finish) ? IDLE : PRESENT;
         default:  w_state_nxt = IDLE;
      endcase
   end

   // Datapath: latching at start, error capture, index/epoch bookkeeping.
   always_ff @(posedge ts_clock) begin
      if (ts_reset) begin
         r_settle     <= 4'd0;
         r_idx        <= 4'd0;
         r_epochs_tgt <= 16'd0;
         r_epoch      <= 16'd0;
         r_done       <= 1'b0;
         r_backprop   <= 0.0;
         r_ratio      <= 0.0;
         r_run_err    <= 0.0;
         r_epoch_err  <= 0.0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (ts_start) begin
                  if (ts_epochs != 16'd0) begin
                     r_epochs_tgt <= ts_epochs;
                     r_ratio      <= ts_ratio_in;
                     r_idx        <= 4'd0;
                     r_epoch      <= 16'd0;
                     r_run_err    <= 0.0;
                     r_settle     <= 4'd0;
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            PRESENT: begin
               r_settle <= (w_state_nxt == CAPTURE) ? 4'd0 : r_settle + 4'd1;
            end
            CAPTURE: begin
               r_backprop <= w_err;
               r_run_err  <= r_run_err + w_err * w_err;
            end
            UPDATE: begin
               // Error was visible for the whole UPDATE cycle; ADVANCE sees 0.
               r_backprop <= 0.0;
            end
            ADVANCE: begin
               if (!w_last) begin
                  r_idx <= r_idx + 4'd1;
               end else begin
                  r_idx       <= 4'd0;
                  r_epoch     <= w_epoch_inc;
                  r_epoch_err <= r_run_err;
                  r_run_err   <= 0.0;
                  if (w_finish) r_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Present the current sample while training; all zero when idle.
   always_comb begin
      for (int d = 0; d < NUM_INPUTS; d++) begin
         ts_dendrites[d] = 0.0;
      end
      if (r_state != IDLE) begin
         ts_dendrites = w_rd_dendrites;
      end
   end

   assign ts_backprop       = r_backprop;
   assign ts_training_ratio = r_ratio;
   assign ts_busy           = (r_state != IDLE);
   assign ts_done           = r_done;
   assign ts_epoch          = r_epoch;
   assign ts_sample_idx     = r_idx;
   assign ts_epoch_error    = r_epoch_err;
   assign ts_dbg_state      = r_state;

endmodule

// File: tb/tb_training_sequencer.sv
// Bench for training_sequencer (NUM_SAMPLES=4, SETTLE_CYCLES=2, 5 cycles
// per sample): reset values, a table-driven single-epoch run, zero-epoch
// start, a three-epoch run with loads/starts issued while busy, reset in
// mid-epoch, and a run against a simple learning neuron model.
module tb_training_sequencer;
   import training_sequencer_pkg::*;

   localparam int NS  = 4;
   localparam int STL = 2;

   logic        ts_clock = 1'b0;
   logic        ts_reset;
   logic        ts_load_valid;
   logic [3:0]  ts_load_index;
   real         ld_dend [NUM_INPUTS];
   real         ts_load_target;
   logic        ts_start;
   logic [15:0] ts_epochs;
   real         ts_ratio_in;
   real         ts_axon;
   real         ts_dendrites [NUM_INPUTS];
   real         ts_backprop;
   real         ts_training_ratio;
   logic        ts_busy;
   logic        ts_done;
   logic [15:0] ts_epoch;
   logic [3:0]  ts_sample_idx;
   real         ts_epoch_error;
   ts_state_t   ts_dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   logic use_neuron = 1'b0;
   real  w [NUM_INPUTS];
   real  neuron_sum;

   typedef struct {
      int        k_lo;
      int        k_hi;
      ts_state_t st;
      int        idx;
      real       bp;
      real       d0;
      real       d1;
      bit        busy;
      bit        done;
   } vec_t;

   vec_t tbl [18];
   real  errs [0:50];

   training_sequencer #(
      .NUM_SAMPLES   (NS),
      .SETTLE_CYCLES (STL)
   ) dut (
      .ts_clock          (ts_clock),
      .ts_reset          (ts_reset),
      .ts_load_valid     (ts_load_valid),
      .ts_load_index     (ts_load_index),
      .ts_load_dendrites (ld_dend),
      .ts_load_target    (ts_load_target),
      .ts_start          (ts_start),
      .ts_epochs         (ts_epochs),
      .ts_ratio_in       (ts_ratio_in),
      .ts_axon           (ts_axon),
      .ts_dendrites      (ts_dendrites),
      .ts_backprop       (ts_backprop),
      .ts_training_ratio (ts_training_ratio),
      .ts_busy           (ts_busy),
      .ts_done           (ts_done),
      .ts_epoch          (ts_epoch),
      .ts_sample_idx     (ts_sample_idx),
      .ts_epoch_error    (ts_epoch_error),
      .ts_dbg_state      (ts_dbg_state)
   );

   // Clock generation.
   always #5 ts_clock = ~ts_clock;

   // Linear neuron model: axon is the dot product of weights and dendrites.
   always_comb begin
      neuron_sum = 0.0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         neuron_sum = neuron_sum + w[i] * ts_dendrites[i];
      end
   end

   assign ts_axon = use_neuron ? neuron_sum : 0.25;

   // Weight commit on the negedge inside UPDATE.
   always @(negedge ts_clock) begin
      if (use_neuron && (ts_dbg_state == UPDATE)) begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            w[i] = w[i] + ts_training_ratio * ts_backprop * ts_dendrites[i];
         end
      end
   end

   task automatic tick();
      @(posedge ts_clock);
      #1;
   endtask

   task automatic chk_i(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_r(input string nm, input real act, input real exp);
      n_checks++;
      if ((act > exp + 1.0e-9) || (act < exp - 1.0e-9)) begin
         n_errors++;
         $display("FAIL %s: got %f expected %f", nm, act, exp);
      end
   endtask

   task automatic load(input int idx, input real d0, input real d1, input real tgt);
      for (int i = 0; i < NUM_INPUTS; i++) ld_dend[i] = 0.0;
      ld_dend[0]     = d0;
      ld_dend[1]     = d1;
      ts_load_index  = 4'(idx);
      ts_load_target = tgt;
      ts_load_valid  = 1'b1;
      tick();
      ts_load_valid  = 1'b0;
   endtask

   task automatic start_run(input int ep, input real ratio);
      ts_epochs   = 16'(ep);
      ts_ratio_in = ratio;
      ts_start    = 1'b1;
      tick();
      ts_start    = 1'b0;
   endtask

   // Returns the cycle index (0 = just after the start edge) of ts_done.
   task automatic run_to_done(input int budget, output int k_done);
      k_done = -1;
      for (int k = 0; k < budget; k++) begin
         if (ts_done === 1'b1) begin
            k_done = k;
            break;
         end
         tick();
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk_i({tag, " state"}, 32'(ts_dbg_state), 32'(IDLE));
      chk_i({tag, " busy"}, 32'(ts_busy), 32'd0);
      chk_i({tag, " done"}, 32'(ts_done), 32'd0);
      chk_i({tag, " epoch"}, 32'(ts_epoch), 32'd0);
      chk_i({tag, " idx"}, 32'(ts_sample_idx), 32'd0);
      chk_r({tag, " backprop"}, ts_backprop, 0.0);
      chk_r({tag, " ratio"}, ts_training_ratio, 0.0);
      chk_r({tag, " epoch_err"}, ts_epoch_error, 0.0);
      chk_r({tag, " dend0"}, ts_dendrites[0], 0.0);
      chk_r({tag, " dend1"}, ts_dendrites[1], 0.0);
   endtask

   initial begin
      int k_done;
      int dones;
      int prev_ep;
      int done_k;

      // Expected per-cycle behaviour of the epochs=1 run, axon tied to 0.25:
      // slot0 {1,0}->1.0 (err 0.75), slot1 {0,1}->0.0 (err -0.25),
      // slots 2,3 zero vector ->0.25 (err 0). Sum of squares 0.625.
      tbl[0]  = '{0,  1,  PRESENT, 0, 0.0,   1.0, 0.0, 1'b1, 1'b0};
      tbl[1]  = '{2,  2,  CAPTURE, 0, 0.0,   1.0, 0.0, 1'b1, 1'b0};
      tbl[2]  = '{3,  3,  UPDATE,  0, 0.75,  1.0, 0.0, 1'b1, 1'b0};
      tbl[3]  = '{4,  4,  ADVANCE, 0, 0.0,   1.0, 0.0, 1'b1, 1'b0};
      tbl[4]  = '{5,  6,  PRESENT, 1, 0.0,   0.0, 1.0, 1'b1, 1'b0};
      tbl[5]  = '{7,  7,  CAPTURE, 1, 0.0,   0.0, 1.0, 1'b1, 1'b0};
      tbl[6]  = '{8,  8,  UPDATE,  1, -0.25, 0.0, 1.0, 1'b1, 1'b0};
      tbl[7]  = '{9,  9,  ADVANCE, 1, 0.0,   0.0, 1.0, 1'b1, 1'b0};
      tbl[8]  = '{10, 11, PRESENT, 2, 0.0,   0.0, 0.0, 1'b1, 1'b0};
      tbl[9]  = '{12, 12, CAPTURE, 2, 0.0,   0.0, 0.0, 1'b1, 1'b0};
      tbl[10] = '{13, 13, UPDATE,  2, 0.0,   0.0, 0.0, 1'b1, 1'b0};
      tbl[11] = '{14, 14, ADVANCE, 2, 0.0,   0.0, 0.0, 1'b1, 1'b0};
      tbl[12] = '{15, 16, PRESENT, 3, 0.0,   0.0, 0.0, 1'b1, 1'b0};
      tbl[13] = '{17, 17, CAPTURE, 3, 0.0,   0.0, 0.0, 1'b1, 1'b0};
      tbl[14] = '{18, 18, UPDATE,  3, 0.0,   0.0, 0.0, 1'b1, 1'b0};
      tbl[15] = '{19, 19, ADVANCE, 3, 0.0,   0.0, 0.0, 1'b1, 1'b0};
      tbl[16] = '{20, 20, IDLE,    0, 0.0,   0.0, 0.0, 1'b0, 1'b1};
      tbl[17] = '{21, 21, IDLE,    0, 0.0,   0.0, 0.0, 1'b0, 1'b0};

      for (int i = 0; i < NUM_INPUTS; i++) begin
         ld_dend[i] = 0.0;
         w[i]       = 0.0;
      end
      ts_reset       = 1'b1;
      ts_load_valid  = 1'b0;
      ts_load_index  = 4'd0;
      ts_load_target = 0.0;
      ts_start       = 1'b0;
      ts_epochs      = 16'd0;
      ts_ratio_in    = 0.0;
      repeat (3) tick();
      ts_reset = 1'b0;
      chk_idle_zero("reset");

      // Load samples; index 7 is out of range and must not land anywhere.
      load(0, 1.0, 0.0, 1.0);
      load(1, 0.0, 1.0, 0.0);
      load(2, 0.0, 0.0, 0.25);
      load(3, 0.0, 0.0, 0.25);
      load(7, 5.0, 5.0, 9.0);
      chk_r("idle dend0 after load", ts_dendrites[0], 0.0);

      // Single-epoch run, table-driven per cycle.
      start_run(1, 0.5);
      for (int e = 0; e < 18; e++) begin
         for (int k = tbl[e].k_lo; k <= tbl[e].k_hi; k++) begin
            chk_i($sformatf("run1 k%0d state", k), 32'(ts_dbg_state), 32'(tbl[e].st));
            chk_i($sformatf("run1 k%0d idx", k), 32'(ts_sample_idx), 32'(tbl[e].idx));
            chk_r($sformatf("run1 k%0d backprop", k), ts_backprop, tbl[e].bp);
            chk_r($sformatf("run1 k%0d dend0", k), ts_dendrites[0], tbl[e].d0);
            chk_r($sformatf("run1 k%0d dend1", k), ts_dendrites[1], tbl[e].d1);
            chk_i($sformatf("run1 k%0d busy", k), 32'(ts_busy), 32'(tbl[e].busy));
            chk_i($sformatf("run1 k%0d done", k), 32'(ts_done), 32'(tbl[e].done));
            tick();
         end
      end
      chk_r("run1 epoch_err", ts_epoch_error, 0.625);
      chk_i("run1 epoch", 32'(ts_epoch), 32'd1);
      chk_r("run1 ratio", ts_training_ratio, 0.5);

      // Zero-epoch start: done pulse only, never busy, ratio not relatched.
      start_run(0, 3.0);
      chk_i("zero done", 32'(ts_done), 32'd1);
      chk_i("zero busy", 32'(ts_busy), 32'd0);
      chk_r("zero ratio", ts_training_ratio, 0.5);
      tick();
      chk_i("zero done2", 32'(ts_done), 32'd0);
      chk_i("zero busy2", 32'(ts_busy), 32'd0);

      // Three epochs with a load and a start issued while busy.
      start_run(3, 0.5);
      ts_epochs = 16'd1;
      dones   = 0;
      prev_ep = 0;
      done_k  = -1;
      for (int k = 0; k < 70; k++) begin
         if (ts_done === 1'b1) begin
            dones++;
            done_k = k;
         end
         if (int'(ts_epoch) != prev_ep) begin
            chk_i($sformatf("run3 k%0d epoch step", k), 32'(ts_epoch), 32'(prev_ep + 1));
            chk_i($sformatf("run3 k%0d idx wrap", k), 32'(ts_sample_idx), 32'd0);
            chk_r($sformatf("run3 k%0d epoch_err", k), ts_epoch_error, 0.625);
            prev_ep = int'(ts_epoch);
         end
         if (k == 7) begin
            for (int i = 0; i < NUM_INPUTS; i++) ld_dend[i] = 0.0;
            ts_load_index  = 4'd0;
            ts_load_target = 5.0;
            ts_load_valid  = 1'b1;
            ts_epochs      = 16'd9;
            ts_ratio_in    = 7.0;
            ts_start       = 1'b1;
         end
         if (k == 8) begin
            ts_load_valid = 1'b0;
            ts_start      = 1'b0;
         end
         tick();
      end
      chk_i("run3 done count", 32'(dones), 32'd1);
      chk_i("run3 done cycle", 32'(done_k), 32'd60);
      chk_i("run3 final epoch", 32'(ts_epoch), 32'd3);
      chk_r("run3 ratio", ts_training_ratio, 0.5);
      chk_i("run3 busy end", 32'(ts_busy), 32'd0);

      // Reset during CAPTURE of sample 1.
      start_run(1, 0.5);
      repeat (7) tick();
      chk_i("rstmid state", 32'(ts_dbg_state), 32'(CAPTURE));
      chk_i("rstmid idx", 32'(ts_sample_idx), 32'd1);
      ts_reset = 1'b1;
      tick();
      ts_reset = 1'b0;
      chk_idle_zero("rstmid");

      // Clean rerun: storage now all zero, each sample err -0.25.
      start_run(1, 0.5);
      run_to_done(40, k_done);
      chk_i("rerun done cycle", 32'(k_done), 32'd20);
      chk_r("rerun epoch_err", ts_epoch_error, 0.25);
      chk_i("rerun epoch", 32'(ts_epoch), 32'd1);

      // Learning neuron on AND-like samples, 50 epochs.
      load(0, 1.0, 1.0, 1.0);
      load(1, 1.0, 0.0, 0.0);
      load(2, 0.0, 1.0, 0.0);
      load(3, 0.0, 0.0, 0.0);
      use_neuron = 1'b1;
      for (int e = 0; e <= 50; e++) errs[e] = -1.0;
      start_run(50, 0.5);
      prev_ep = 0;
      k_done  = -1;
      for (int k = 0; k < 1100; k++) begin
         if (int'(ts_epoch) != prev_ep) begin
            prev_ep = int'(ts_epoch);
            if (prev_ep <= 50) errs[prev_ep] = ts_epoch_error;
         end
         if (ts_done === 1'b1) begin
            k_done = k;
            break;
         end
         tick();
      end
      chk_i("neuron done cycle", 32'(k_done), 32'd1000);
      chk_i("neuron epoch", 32'(ts_epoch), 32'd50);
      chk_r("neuron err ep1", errs[1], 1.5);
      chk_r("neuron err ep2", errs[2], 0.75);
      for (int e = 41; e <= 50; e++) begin
         n_checks++;
         if (errs[e] > errs[e - 1] + 1.0e-12) begin
            n_errors++;
            $display("FAIL neuron err ep%0d: got %f expected <= %f", e, errs[e], errs[e - 1]);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/training_sequencer.md
TRAINING_SEQUENCER -- requirements
Module: training_sequencer

Interface
REQ-001 The module SHALL have parameter NUM_SAMPLES, default 4, meaning the number of stored training samples (range 1-16).
REQ-002 The module SHALL have parameter SETTLE_CYCLES, default 2, meaning the clocks allowed for the neuron axon to settle after a sample is presented (range 1-15).
REQ-003 The module SHALL have port ts_clock, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 The module SHALL have port ts_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port ts_load_valid, input, 1 bit: write one sample this cycle.
REQ-006 The module SHALL have port ts_load_index, input, 4 bits: sample slot to write.
REQ-007 The module SHALL have port ts_load_dendrites, input, real[31:0]: sample input vector.
REQ-008 The module SHALL have port ts_load_target, input, real: sample target output.
REQ-009 The module SHALL have port ts_start, input, 1 bit: single-cycle pulse that begins training.
REQ-010 The module SHALL have port ts_epochs, input, 16 bits: number of epochs to run, sampled at start.
REQ-011 The module SHALL have port ts_ratio_in, input, real: training ratio, sampled at start.
REQ-012 The module SHALL have port ts_axon, input, real: neuron output.
REQ-013 The module SHALL have port ts_dendrites, output, real[31:0]: vector presented to the neuron.
REQ-014 The module SHALL have port ts_backprop, output, real: error term driven to the neuron.
REQ-015 The module SHALL have port ts_training_ratio, output, real: latched training ratio.
REQ-016 The module SHALL have port ts_busy, output, 1 bit: high while training.
REQ-017 The module SHALL have port ts_done, output, 1 bit: one-cycle pulse when the final epoch completes.
REQ-018 The module SHALL have port ts_epoch, output, 16 bits: number of completed epochs.
REQ-019 The module SHALL have port ts_sample_idx, output, 4 bits: index of the current sample.
REQ-020 The module SHALL have port ts_epoch_error, output, real: sum of squared errors of the last completed epoch.

Function
REQ-021 The FSM SHALL have states IDLE, PRESENT, CAPTURE, UPDATE and ADVANCE.
REQ-022 In IDLE, ts_load_valid with ts_load_index < NUM_SAMPLES SHALL write that slot on the next edge; indices >= NUM_SAMPLES SHALL be ignored.
REQ-023 Loads outside IDLE SHALL be ignored.
REQ-024 In IDLE, ts_start with ts_epochs != 0 SHALL latch ts_epochs and ts_ratio_in, clear the sample index, epoch count and running error, and enter PRESENT.
REQ-025 ts_start with ts_epochs == 0 SHALL produce a ts_done pulse on the next cycle and remain in IDLE.
REQ-026 In PRESENT, ts_dendrites SHALL equal the current sample, ts_backprop SHALL be 0.0, and a settle counter SHALL run SETTLE_CYCLES cycles before the FSM moves to CAPTURE.
REQ-027 CAPTURE SHALL register err = target - ts_axon into ts_backprop, add err*err to the running error, and move to UPDATE.
REQ-028 UPDATE SHALL hold ts_backprop and ts_dendrites unchanged for exactly one full clock, so that a negedge weight commit sees a stable error, then move to ADVANCE.
REQ-029 ADVANCE SHALL clear ts_backprop to 0.0.
REQ-030 In ADVANCE, if the sample index is below NUM_SAMPLES-1, the index SHALL increment and the FSM SHALL enter PRESENT.
REQ-031 Otherwise ADVANCE SHALL wrap the index to 0, increment ts_epoch, copy the running error to ts_epoch_error and clear the running error.
REQ-032 After that wrap, the FSM SHALL enter IDLE with ts_done pulsed if ts_epoch reached the latched count, else enter PRESENT.
REQ-033 Cycles per sample SHALL be SETTLE_CYCLES+3.
REQ-034 ts_busy SHALL be high in every state except IDLE.
REQ-035 ts_start while busy SHALL be ignored.
REQ-036 ts_training_ratio SHALL hold the latched value until the next accepted start.
REQ-037 ts_epoch SHALL saturate at 16'hFFFF.
REQ-038 ts_dendrites SHALL be all 0.0 in IDLE.

Reset
REQ-039 ts_reset SHALL, on a clock edge, force IDLE from any state, including mid-epoch.
REQ-040 Reset SHALL drive ts_backprop, ts_training_ratio, ts_epoch_error and every ts_dendrites entry to 0.0.
REQ-041 Reset SHALL clear ts_busy, ts_done, ts_epoch and ts_sample_idx to 0.
REQ-042 Reset SHALL clear all sample slots to 0.0.

Structure
REQ-043 A shared package SHALL hold the FSM state enum, NUM_INPUTS=32 and the sample record typedef (real[31:0] dendrites, real target).
REQ-044 Sample storage SHALL be one sub-module, sample_store: a register-array write port with a combinational read port.

Verification
REQ-045 Load samples {1,0,...}->1.0 and {0,1,...}->0.0, tie ts_axon=0.25, start with epochs=1 -> ts_backprop 0.75 then -0.25 in the respective UPDATE states; ts_epoch_error 0.625; ts_done 4*(SETTLE+3)+1 cycles after start.
REQ-046 Start with epochs=3 -> ts_epoch steps 1,2,3; ts_sample_idx wraps to 0 each epoch; exactly one ts_done pulse.
REQ-047 Assert ts_reset during CAPTURE of sample 1 -> next cycle IDLE with all outputs 0; a subsequent start runs cleanly.
REQ-048 ts_start with epochs=0 -> ts_done for one cycle, ts_busy never high.
REQ-049 ts_load_valid and ts_start while busy -> storage unchanged and run unaffected; load index 7 with NUM_SAMPLES=4 -> ignored.
REQ-050 Connect to a learning neuron, two samples AND-like, ratio 0.5, epochs=50 -> ts_epoch_error is non-increasing across the final 10 epochs.
